// File: rtl/asip_mem_pkg.sv
// Shared types and constants for the ASIP data-memory responder.
package asip_mem_pkg;

   localparam int unsigned DATA_W         = 17;
   localparam int unsigned ADDR_W_DEFAULT = 10;
   localparam int unsigned CNT_W          = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

   // Source of ReadData for the most recent response
   typedef enum logic [1:0] {RD_ZERO, RD_RAM, RD_ECHO} rd_sel_t;

   typedef struct packed {
      logic              write;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM: write-enable, registered read, contents not reset.
module dmem_array #(
   parameter int unsigned DATA_W = 17,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Read data only updates on an enabled read, so it holds across writes
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency request/response front end to the ASIP data RAM, with a preload port.
module data_mem_responder
   import asip_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              MemWrite,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] WriteData,
   output logic              resp_valid,
   output logic [DATA_W-1:0] ReadData,
   output logic              resp_err,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready
);

   mem_state_t        state;
   logic [CNT_W-1:0]  cnt;
   mem_req_t          req_q;
   mem_req_t          live_req;
   mem_req_t          cpu_req;
   rd_sel_t           rd_sel;
   logic [DATA_W-1:0] echo_q;

   logic              accept;
   logic              ld_fire;
   logic              cpu_go;
   logic              oor;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Handshakes: the loader has priority over the CPU while idle
   always_comb begin
      req_ready = (state == IDLE) && !ld_we;
      ld_ready  = (state == IDLE);
      accept    = req_valid && req_ready;
      ld_fire   = ld_ready && ld_we;
   end

   // While idle the live bus is used so a zero-wait access hits the RAM on the accept edge
   always_comb begin
      live_req.write = MemWrite;
      live_req.addr  = ALUResult;
      live_req.wdata = WriteData;
      cpu_req        = (state == IDLE) ? live_req : req_q;
      oor            = |cpu_req.addr[DATA_W-1:ADDR_W];
      cpu_go         = !reset && (((WAIT_CYCLES == 0) && accept) ||
                                  ((state == WAIT) && (cnt == '0)));
   end

   // Loader / CPU mux in front of the RAM; reset blocks any write
   always_comb begin
      ram_en    = (ld_fire && !reset) || (cpu_go && !oor);
      ram_we    = ld_fire ? 1'b1    : cpu_req.write;
      ram_addr  = ld_fire ? ld_addr : cpu_req.addr[ADDR_W-1:0];
      ram_wdata = ld_fire ? ld_data : cpu_req.wdata;
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         req_q      <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         rd_sel     <= RD_ZERO;
         echo_q     <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  req_q <= live_req;
                  if (WAIT_CYCLES == 0) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_W'(WAIT_CYCLES - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) state <= RESP;
               else           cnt   <= cnt - CNT_W'(1);
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         // Response fields are set on the edge entering RESP and held until the next one
         if (cpu_go) begin
            resp_valid <= 1'b1;
            resp_err   <= oor;
            echo_q     <= cpu_req.wdata;
            if (oor)                rd_sel <= RD_ZERO;
            else if (cpu_req.write) rd_sel <= RD_ECHO;
            else                    rd_sel <= RD_RAM;
         end
      end
   end

   always_comb begin
      case (rd_sel)
         RD_RAM:  ReadData = ram_rdata;
         RD_ECHO: ReadData = echo_q;
         default: ReadData = '0;
      endcase
   end

endmodule
